// File: rtl/noc_local_ni.sv
// Local network interface between a processing element and one NoC router port.
// Injection: PE requests become 16-bit flits {payload, dst, 1'b1}. They are queued
// and written to the router's local input FIFO under full/almost-full flow control.
// Ejection: flits from the router's local output go into a first-word-fall-through
// FIFO. The FIFO returns full/almost-full to the router and hands payloads to the
// PE through a valid/ready handshake.
module noc_local_ni #(
    parameter logic [1:0] LOCAL_IP  = 2'b00,
    parameter int         INJ_DEPTH = 4,
    parameter int         EJ_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inj_valid,
    output logic        inj_ready,
    input  logic [1:0]  inj_dst,
    input  logic [12:0] inj_payload,

    output logic        ni_write,
    output logic [15:0] ni_data,
    input  logic        rtr_full,
    input  logic        rtr_almost_full,

    input  logic        rtr_write,
    input  logic [15:0] rtr_data,
    output logic        ni_full,
    output logic        ni_almost_full,

    output logic        ej_valid,
    input  logic        ej_ready,
    output logic [12:0] ej_payload,
    output logic        ej_misroute,

    output logic        overflow,
    output logic [15:0] inj_count,
    output logic [15:0] ej_count
);

    localparam int INJ_AW = $clog2(INJ_DEPTH);
    localparam int INJ_CW = INJ_AW + 1;
    localparam int EJ_AW  = $clog2(EJ_DEPTH);
    localparam int EJ_CW  = EJ_AW + 1;

    localparam logic [INJ_AW-1:0] INJ_PTR_ONE = INJ_AW'(1);
    localparam logic [INJ_CW-1:0] INJ_CNT_ONE = INJ_CW'(1);
    localparam logic [INJ_CW-1:0] INJ_FULL    = INJ_CW'(INJ_DEPTH);
    localparam logic [EJ_AW-1:0]  EJ_PTR_ONE  = EJ_AW'(1);
    localparam logic [EJ_CW-1:0]  EJ_CNT_ONE  = EJ_CW'(1);
    localparam logic [EJ_CW-1:0]  EJ_FULL     = EJ_CW'(EJ_DEPTH);
    // Two slots of headroom cover writes already in flight in the router's
    // registered output stage when almost-full is seen.
    localparam logic [EJ_CW-1:0]  EJ_AFULL    = EJ_CW'(EJ_DEPTH - 2);

    // ------------------------------------------------------------------
    // Injection queue
    // ------------------------------------------------------------------
    logic [15:0]       injMem [INJ_DEPTH];
    logic [INJ_AW-1:0] injWrPtr;
    logic [INJ_AW-1:0] injRdPtr;
    logic [INJ_CW-1:0] injCount;
    logic [15:0]       injFlit;
    logic              injEnq;
    logic              injIssue;
    logic              sendAble;
    logic              vld_p1;
    logic [15:0]       flit_p1;
    logic [15:0]       injCountReg;

    assign injFlit   = {inj_payload, inj_dst, 1'b1};
    assign inj_ready = (injCount != INJ_FULL);
    assign injEnq    = inj_valid & inj_ready;
    assign injIssue  = sendAble & (injCount != '0);

    // Injection storage: data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (injEnq) begin
            injMem[injWrPtr] <= injFlit;
        end
    end

    // Injection pointers and occupancy. Enqueue and issue in the same cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            injWrPtr <= '0;
            injRdPtr <= '0;
            injCount <= '0;
        end else begin
            if (injEnq) begin
                injWrPtr <= injWrPtr + INJ_PTR_ONE;
            end
            if (injIssue) begin
                injRdPtr <= injRdPtr + INJ_PTR_ONE;
            end
            case ({injEnq, injIssue})
                2'b10:   injCount <= injCount + INJ_CNT_ONE;
                2'b01:   injCount <= injCount - INJ_CNT_ONE;
                default: injCount <= injCount;
            endcase
        end
    end

    // Send permission. It drops for one cycle when the router nears full while we are writing.
    always_ff @(posedge clk) begin
        if (reset) begin
            sendAble <= 1'b0;
        end else begin
            sendAble <= !((rtr_almost_full & vld_p1) | rtr_full);
        end
    end

    // Registered router write port. ni_data is held at zero whenever no flit is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            flit_p1 <= '0;
        end else begin
            vld_p1  <= injIssue;
            flit_p1 <= injIssue ? injMem[injRdPtr] : 16'h0000;
        end
    end

    // Injected flit counter. It wraps modulo 2^16.
    always_ff @(posedge clk) begin
        if (reset) begin
            injCountReg <= '0;
        end else if (vld_p1) begin
            injCountReg <= injCountReg + 16'd1;
        end
    end

    assign ni_write  = vld_p1;
    assign ni_data   = flit_p1;
    assign inj_count = injCountReg;

    // ------------------------------------------------------------------
    // Ejection FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    // The valid bit is implied by acceptance, so only bits [15:1] are stored.
    logic [15:1]      ejMem [EJ_DEPTH];
    logic [EJ_AW-1:0] ejWrPtr;
    logic [EJ_AW-1:0] ejRdPtr;
    logic [EJ_CW-1:0] ejCount;
    logic [15:1]      ejHead;
    logic             ejNotEmpty;
    logic             ejPush;
    logic             ejPop;
    logic             ejAccept;
    logic             ejDrop;
    logic             overflowReg;
    logic [15:0]      ejCountReg;

    assign ejNotEmpty = (ejCount != '0);
    assign ejPush     = rtr_write & rtr_data[0];
    assign ejPop      = ejNotEmpty & ej_ready;
    // A full FIFO still accepts a flit when the PE frees a slot in the same cycle.
    assign ejAccept   = ejPush & ((ejCount != EJ_FULL) | ejPop);
    assign ejDrop     = ejPush & ~ejAccept;

    // Ejection storage: data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (ejAccept) begin
            ejMem[ejWrPtr] <= rtr_data[15:1];
        end
    end

    // Ejection pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            ejWrPtr <= '0;
            ejRdPtr <= '0;
            ejCount <= '0;
        end else begin
            if (ejAccept) begin
                ejWrPtr <= ejWrPtr + EJ_PTR_ONE;
            end
            if (ejPop) begin
                ejRdPtr <= ejRdPtr + EJ_PTR_ONE;
            end
            case ({ejAccept, ejPop})
                2'b10:   ejCount <= ejCount + EJ_CNT_ONE;
                2'b01:   ejCount <= ejCount - EJ_CNT_ONE;
                default: ejCount <= ejCount;
            endcase
        end
    end

    // Sticky drop flag and the accepted-flit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflowReg <= 1'b0;
            ejCountReg  <= '0;
        end else begin
            if (ejDrop) begin
                overflowReg <= 1'b1;
            end
            if (ejAccept) begin
                ejCountReg <= ejCountReg + 16'd1;
            end
        end
    end

    assign ejHead         = ejMem[ejRdPtr];
    assign ej_valid       = ejNotEmpty;
    assign ej_payload     = ejNotEmpty ? ejHead[15:3] : 13'h0000;
    assign ej_misroute    = ejNotEmpty & (ejHead[2:1] != LOCAL_IP);
    assign ni_full        = (ejCount == EJ_FULL);
    assign ni_almost_full = (ejCount >= EJ_AFULL);
    assign overflow       = overflowReg;
    assign ej_count       = ejCountReg;

endmodule

// File: tb/tb_noc_local_ni.sv
// Scenario testbench for noc_local_ni. Injected flits and ejected payloads are
// queued when the stimulus is driven, then popped and compared when the DUT
// presents them.
module tb_noc_local_ni;

    logic        clk = 1'b0;
    logic        reset;
    logic        inj_valid;
    logic        inj_ready;
    logic [1:0]  inj_dst;
    logic [12:0] inj_payload;
    logic        ni_write;
    logic [15:0] ni_data;
    logic        rtr_full;
    logic        rtr_almost_full;
    logic        rtr_write;
    logic [15:0] rtr_data;
    logic        ni_full;
    logic        ni_almost_full;
    logic        ej_valid;
    logic        ej_ready;
    logic [12:0] ej_payload;
    logic        ej_misroute;
    logic        overflow;
    logic [15:0] inj_count;
    logic [15:0] ej_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] injQ [$];
    logic [12:0] ejQ  [$];

    always #5 clk = ~clk;

    noc_local_ni #(.LOCAL_IP(2'b00), .INJ_DEPTH(4), .EJ_DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_dst(inj_dst), .inj_payload(inj_payload),
        .ni_write(ni_write), .ni_data(ni_data), .rtr_full(rtr_full), .rtr_almost_full(rtr_almost_full),
        .rtr_write(rtr_write), .rtr_data(rtr_data), .ni_full(ni_full), .ni_almost_full(ni_almost_full),
        .ej_valid(ej_valid), .ej_ready(ej_ready), .ej_payload(ej_payload), .ej_misroute(ej_misroute),
        .overflow(overflow), .inj_count(inj_count), .ej_count(ej_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if (ni_write !== 1'b0) begin errors++; $display("FAIL reset_ni_write actual=%0h required=0", ni_write); end
        checks++; if (ni_data !== 16'h0000) begin errors++; $display("FAIL reset_ni_data actual=%0h required=0", ni_data); end
        checks++; if (dut.sendAble !== 1'b0) begin errors++; $display("FAIL reset_send_able actual=%0h required=0", dut.sendAble); end
        checks++; if (inj_ready !== 1'b1) begin errors++; $display("FAIL reset_inj_ready actual=%0h required=1", inj_ready); end
        checks++; if (ej_valid !== 1'b0) begin errors++; $display("FAIL reset_ej_valid actual=%0h required=0", ej_valid); end
        checks++; if (ni_full !== 1'b0 || ni_almost_full !== 1'b0) begin errors++; $display("FAIL reset_ni_full actual=%0h/%0h required=0/0", ni_full, ni_almost_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow actual=%0h required=0", overflow); end
        checks++; if (inj_count !== 16'd0 || ej_count !== 16'd0) begin errors++; $display("FAIL reset_counts actual=%0h/%0h required=0/0", inj_count, ej_count); end
        checks++; if (ej_payload !== 13'd0 || ej_misroute !== 1'b0) begin errors++; $display("FAIL reset_ej_outputs actual=%0h/%0h required=0/0", ej_payload, ej_misroute); end
    endtask

    task automatic test_latency();
        logic [15:0] exp;
        // cycle 0
        checks++; if (inj_ready !== 1'b1) begin errors++; $display("FAIL lat_inj_ready actual=%0h required=1", inj_ready); end
        inj_valid = 1'b1;
        inj_dst = 2'b01;
        inj_payload = 13'h0ABC;
        injQ.push_back(16'h55E3);
        step();
        inj_valid = 1'b0;
        // cycle 1
        checks++; if (ni_write !== 1'b0 || ni_data !== 16'h0000) begin errors++; $display("FAIL lat_cycle1 actual=%0h/%0h required=0/0", ni_write, ni_data); end
        step();
        // cycle 2
        checks++; if (ni_write !== 1'b1) begin errors++; $display("FAIL lat_cycle2_write actual=%0h required=1", ni_write); end
        if (ni_write === 1'b1 && injQ.size() > 0) begin
            exp = injQ.pop_front();
            checks++; if (ni_data !== exp) begin errors++; $display("FAIL lat_ni_data actual=%0h required=%0h", ni_data, exp); end
        end
        step();
        checks++; if (inj_count !== 16'd1) begin errors++; $display("FAIL lat_inj_count actual=%0d required=1", inj_count); end
        checks++; if (ni_write !== 1'b0) begin errors++; $display("FAIL lat_single_write actual=%0h required=0", ni_write); end
        injQ.delete();
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int seen = 0;
        int first = -1;
        int last = -1;
        logic [15:0] exp;
        rtr_full = 1'b1;
        step();
        for (int j = 0; j < 6; j++) begin
            inj_valid = 1'b1;
            inj_dst = 2'(acc);
            inj_payload = 13'h0100 + 13'(acc);
            checks++; if (inj_ready !== (acc < 4)) begin errors++; $display("FAIL b2b_inj_ready_%0d actual=%0h required=%0h", j, inj_ready, (acc < 4)); end
            checks++; if (ni_write !== 1'b0) begin errors++; $display("FAIL b2b_blocked_write_%0d actual=%0h required=0", j, ni_write); end
            if (acc < 4) begin
                injQ.push_back({13'h0100 + 13'(acc), 2'(acc), 1'b1});
                acc++;
            end
            step();
        end
        inj_valid = 1'b0;
        rtr_full = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (ni_write === 1'b1) begin
                if (first < 0) first = i;
                last = i;
                seen++;
                if (injQ.size() == 0) begin
                    checks++; errors++; $display("FAIL b2b_extra_flit actual=%0h required=none", ni_data);
                end else begin
                    exp = injQ.pop_front();
                    checks++; if (ni_data !== exp) begin errors++; $display("FAIL b2b_ni_data actual=%0h required=%0h", ni_data, exp); end
                end
            end
            step();
        end
        checks++; if (seen != 4) begin errors++; $display("FAIL b2b_flit_count actual=%0d required=4", seen); end
        checks++; if (last - first != 3) begin errors++; $display("FAIL b2b_span actual=%0d required=3", last - first); end
        checks++; if (inj_count !== 16'd5) begin errors++; $display("FAIL b2b_inj_count actual=%0d required=5", inj_count); end
        injQ.delete();
    endtask

    task automatic test_almost_full_gap();
        int first = -1;
        int seen = 0;
        logic wr [12];
        logic pat [5];
        logic [15:0] exp;
        pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
        rtr_full = 1'b1;
        step();
        for (int j = 0; j < 4; j++) begin
            inj_valid = 1'b1;
            inj_dst = 2'b11;
            inj_payload = 13'h1A00 + 13'(j);
            checks++; if (inj_ready !== 1'b1) begin errors++; $display("FAIL afg_inj_ready_%0d actual=%0h required=1", j, inj_ready); end
            injQ.push_back({13'h1A00 + 13'(j), 2'b11, 1'b1});
            step();
        end
        inj_valid = 1'b0;
        rtr_full = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wr[i] = ni_write;
            if (first >= 0 && i == first + 1) begin
                checks++; if (dut.sendAble !== 1'b0) begin errors++; $display("FAIL afg_send_able actual=%0h required=0", dut.sendAble); end
            end
            if (ni_write === 1'b1 && first < 0) begin
                first = i;
                rtr_almost_full = 1'b1;
            end else begin
                rtr_almost_full = 1'b0;
            end
            if (ni_write === 1'b1) begin
                seen++;
                if (injQ.size() == 0) begin
                    checks++; errors++; $display("FAIL afg_extra_flit actual=%0h required=none", ni_data);
                end else begin
                    exp = injQ.pop_front();
                    checks++; if (ni_data !== exp) begin errors++; $display("FAIL afg_ni_data actual=%0h required=%0h", ni_data, exp); end
                end
            end
            step();
        end
        rtr_almost_full = 1'b0;
        if (first < 0 || first + 4 >= 12) begin
            checks++; errors++; $display("FAIL afg_no_write actual=%0d required=0..7", first);
        end else begin
            for (int o = 0; o < 5; o++) begin
                checks++; if (wr[first + o] !== pat[o]) begin errors++; $display("FAIL afg_pattern_%0d actual=%0h required=%0h", o, wr[first + o], pat[o]); end
            end
        end
        checks++; if (seen != 4) begin errors++; $display("FAIL afg_flit_count actual=%0d required=4", seen); end
        checks++; if (inj_count !== 16'd9) begin errors++; $display("FAIL afg_inj_count actual=%0d required=9", inj_count); end
        injQ.delete();
    endtask

    task automatic test_ej_fill();
        int drained = 0;
        logic [12:0] exp;
        ej_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rtr_write = 1'b1;
            rtr_data = {13'h0100 + 13'(i), 2'b00, 1'b1};
            ejQ.push_back(13'h0100 + 13'(i));
            step();
            checks++; if (ni_almost_full !== ((i + 1) >= 6)) begin errors++; $display("FAIL ej_almost_full_cnt%0d actual=%0h required=%0h", i + 1, ni_almost_full, ((i + 1) >= 6)); end
            checks++; if (ni_full !== ((i + 1) == 8)) begin errors++; $display("FAIL ej_full_cnt%0d actual=%0h required=%0h", i + 1, ni_full, ((i + 1) == 8)); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ej_overflow_early actual=%0h required=0", overflow); end
        // ninth push into a full FIFO with no pop is dropped
        rtr_data = {13'h1FFF, 2'b00, 1'b1};
        step();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ej_overflow_set actual=%0h required=1", overflow); end
        checks++; if (ej_count !== 16'd8) begin errors++; $display("FAIL ej_count_drop actual=%0d required=8", ej_count); end
        // ninth push with a simultaneous pop is accepted
        rtr_data = {13'h01AA, 2'b00, 1'b1};
        ej_ready = 1'b1;
        if (ejQ.size() > 0) begin
            exp = ejQ.pop_front();
            checks++; if (ej_payload !== exp) begin errors++; $display("FAIL ej_head_full actual=%0h required=%0h", ej_payload, exp); end
        end
        ejQ.push_back(13'h01AA);
        step();
        rtr_write = 1'b0;
        ej_ready = 1'b0;
        checks++; if (ej_count !== 16'd9) begin errors++; $display("FAIL ej_count_pop_push actual=%0d required=9", ej_count); end
        checks++; if (ni_full !== 1'b1) begin errors++; $display("FAIL ej_full_after_swap actual=%0h required=1", ni_full); end
        ej_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (ej_valid !== 1'b1) break;
            drained++;
            if (ejQ.size() == 0) begin
                checks++; errors++; $display("FAIL ej_extra_payload actual=%0h required=none", ej_payload);
            end else begin
                exp = ejQ.pop_front();
                checks++; if (ej_payload !== exp || ej_misroute !== 1'b0) begin errors++; $display("FAIL ej_drain_payload actual=%0h/%0h required=%0h/0", ej_payload, ej_misroute, exp); end
            end
            step();
        end
        ej_ready = 1'b0;
        checks++; if (drained != 8) begin errors++; $display("FAIL ej_drain_count actual=%0d required=8", drained); end
        checks++; if (ej_valid !== 1'b0 || ni_almost_full !== 1'b0) begin errors++; $display("FAIL ej_empty_after_drain actual=%0h/%0h required=0/0", ej_valid, ni_almost_full); end
        ejQ.delete();
    endtask

    task automatic test_misroute();
        rtr_write = 1'b1;
        rtr_data = 16'h0005;
        step();
        rtr_write = 1'b0;
        checks++; if (ej_valid !== 1'b1) begin errors++; $display("FAIL mis_ej_valid actual=%0h required=1", ej_valid); end
        checks++; if (ej_payload !== 13'h0000) begin errors++; $display("FAIL mis_payload actual=%0h required=0", ej_payload); end
        checks++; if (ej_misroute !== 1'b1) begin errors++; $display("FAIL mis_misroute actual=%0h required=1", ej_misroute); end
        checks++; if (ej_count !== 16'd10) begin errors++; $display("FAIL mis_ej_count actual=%0d required=10", ej_count); end
        rtr_write = 1'b1;
        rtr_data = 16'h0004;
        step();
        rtr_write = 1'b0;
        checks++; if (ej_count !== 16'd10) begin errors++; $display("FAIL idle_ej_count actual=%0d required=10", ej_count); end
        ej_ready = 1'b1;
        step();
        ej_ready = 1'b0;
        checks++; if (ej_valid !== 1'b0) begin errors++; $display("FAIL idle_not_queued actual=%0h required=0", ej_valid); end
    endtask

    task automatic test_reset_midop();
        rtr_full = 1'b1;
        step();
        for (int j = 0; j < 2; j++) begin
            inj_valid = 1'b1;
            inj_dst = 2'b10;
            inj_payload = 13'h0777 + 13'(j);
            step();
        end
        inj_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            rtr_write = 1'b1;
            rtr_data = {13'h0333 + 13'(j), 2'b00, 1'b1};
            step();
        end
        rtr_write = 1'b0;
        checks++; if (ej_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_ej_valid actual=%0h required=1", ej_valid); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (ej_valid !== 1'b0) begin errors++; $display("FAIL mid_ej_valid actual=%0h required=0", ej_valid); end
        checks++; if (inj_ready !== 1'b1) begin errors++; $display("FAIL mid_inj_ready actual=%0h required=1", inj_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow actual=%0h required=0", overflow); end
        checks++; if (inj_count !== 16'd0 || ej_count !== 16'd0) begin errors++; $display("FAIL mid_counts actual=%0d/%0d required=0/0", inj_count, ej_count); end
        checks++; if (ni_full !== 1'b0 || ni_almost_full !== 1'b0) begin errors++; $display("FAIL mid_ni_full actual=%0h/%0h required=0/0", ni_full, ni_almost_full); end
        rtr_full = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (ni_write !== 1'b0) begin errors++; $display("FAIL mid_discarded_write_%0d actual=%0h required=0", i, ni_write); end
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        inj_valid = 1'b0;
        inj_dst = 2'b00;
        inj_payload = 13'h0000;
        rtr_full = 1'b0;
        rtr_almost_full = 1'b0;
        rtr_write = 1'b0;
        rtr_data = 16'h0000;
        ej_ready = 1'b0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_almost_full_gap();
        test_ej_fill();
        test_misroute();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
